// File: rtl/ddr4_cmd_issuer.sv
// Open-page DDR4 command issuer: turns single read/write requests into the minimal
// PRE/ACT/RD/WR sequence, tracking the open row of each bank.
module ddr4_cmd_issuer #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRP       = 3,
  parameter int TRCD      = 3,
  parameter int TBURST    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 cs_n,
  output logic                 cke,
  output logic                 row_hit,
  output logic                 cmd_done
);

  localparam int BKW   = BGWIDTH + BAWIDTH;
  localparam int NBANK = 2 ** BKW;

  typedef enum logic [2:0] {
    IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, COL, WAIT_BURST
  } state_t;

  state_t state, state_nxt;
  logic [7:0] cnt, cnt_nxt;

  logic                 wr_q;
  logic [BGWIDTH-1:0]   bg_q;
  logic [BAWIDTH-1:0]   ba_q;
  logic [ADDRWIDTH-1:0] row_q;
  logic [COLWIDTH-1:0]  col_q;

  logic [NBANK-1:0]     open_q;
  logic [ADDRWIDTH-1:0] open_row [NBANK];

  logic           accept;
  logic [BKW-1:0] req_bank;
  logic [BKW-1:0] cur_bank;

  assign accept   = req_valid && req_ready;
  assign req_bank = {req_bg, req_ba};
  assign cur_bank = {bg_q, ba_q};

  // Next-state and wait-counter control
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (open_q[req_bank] && open_row[req_bank] == req_row) state_nxt = COL;
          else if (open_q[req_bank])                             state_nxt = PRE;
          else                                                   state_nxt = ACT;
        end
      end
      PRE: begin
        if (TRP > 1) begin
          state_nxt = WAIT_RP;
          cnt_nxt   = 8'(TRP - 2);
        end else begin
          state_nxt = ACT;
        end
      end
      WAIT_RP: begin
        if (cnt == 8'd0) state_nxt = ACT;
        else             cnt_nxt   = cnt - 8'd1;
      end
      ACT: begin
        if (TRCD > 1) begin
          state_nxt = WAIT_RCD;
          cnt_nxt   = 8'(TRCD - 2);
        end else begin
          state_nxt = COL;
        end
      end
      WAIT_RCD: begin
        if (cnt == 8'd0) state_nxt = COL;
        else             cnt_nxt   = cnt - 8'd1;
      end
      COL: begin
        state_nxt = WAIT_BURST;
        cnt_nxt   = 8'(TBURST - 1);
      end
      WAIT_BURST: begin
        if (cnt == 8'd0) state_nxt = IDLE;
        else             cnt_nxt   = cnt - 8'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 8'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= 1'b0;
      bg_q  <= '0;
      ba_q  <= '0;
      row_q <= '0;
      col_q <= '0;
    end else if (accept) begin
      wr_q  <= req_wr;
      bg_q  <= req_bg;
      ba_q  <= req_ba;
      row_q <= req_row;
      col_q <= req_col;
    end
  end

  // Bank table follows the commands as they are driven on the pins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      open_q <= '0;
    end else if (state == PRE) begin
      open_q[cur_bank] <= 1'b0;
    end else if (state == ACT) begin
      open_q[cur_bank] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == ACT) open_row[cur_bank] <= row_q;
  end

  // Pin values for the coming cycle; on the acceptance edge the fields come
  // straight from the request since the latches update on that same edge.
  logic                 f_wr;
  logic [BGWIDTH-1:0]   f_bg;
  logic [BAWIDTH-1:0]   f_ba;
  logic [ADDRWIDTH-1:0] f_row;
  logic [COLWIDTH-1:0]  f_col;
  logic                 cs_d, act_d, hit_d, done_d;
  logic [ADDRWIDTH-1:0] a_d;
  logic [BGWIDTH-1:0]   bg_d;
  logic [BAWIDTH-1:0]   ba_d;

  always_comb begin
    f_wr   = (state == IDLE) ? req_wr  : wr_q;
    f_bg   = (state == IDLE) ? req_bg  : bg_q;
    f_ba   = (state == IDLE) ? req_ba  : ba_q;
    f_row  = (state == IDLE) ? req_row : row_q;
    f_col  = (state == IDLE) ? req_col : col_q;
    cs_d   = 1'b1;
    act_d  = 1'b1;
    a_d    = '0;
    bg_d   = '0;
    ba_d   = '0;
    hit_d  = 1'b0;
    done_d = 1'b0;
    case (state_nxt)
      PRE: begin
        cs_d       = 1'b0;
        a_d[16:14] = 3'b010;
        bg_d       = f_bg;
        ba_d       = f_ba;
      end
      ACT: begin
        cs_d  = 1'b0;
        act_d = 1'b0;
        a_d   = f_row;
        bg_d  = f_bg;
        ba_d  = f_ba;
      end
      COL: begin
        cs_d                = 1'b0;
        a_d[16:14]          = f_wr ? 3'b100 : 3'b101;
        a_d[COLWIDTH-1:0]   = f_col;
        bg_d                = f_bg;
        ba_d                = f_ba;
        done_d              = 1'b1;
        hit_d               = (state == IDLE);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_n      <= 1'b1;
      act_n     <= 1'b1;
      A         <= '0;
      bg        <= '0;
      ba        <= '0;
      cke       <= 1'b0;
      req_ready <= 1'b0;
      row_hit   <= 1'b0;
      cmd_done  <= 1'b0;
    end else begin
      cs_n      <= cs_d;
      act_n     <= act_d;
      A         <= a_d;
      bg        <= bg_d;
      ba        <= ba_d;
      cke       <= 1'b1;
      req_ready <= (state_nxt == IDLE);
      row_hit   <= hit_d;
      cmd_done  <= done_d;
    end
  end

endmodule

// File: tb/tb_ddr4_cmd_issuer.sv
// Bench for ddr4_cmd_issuer: directed and random requests checked cycle by cycle
// against a command-schedule model built from bank open/row bookkeeping.
module tb_ddr4_cmd_issuer;
  localparam int AW = 17, CW = 10, TRP = 3, TRCD = 3, TBURST = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_wr = 1'b0;
  logic [1:0]    req_bg = '0, req_ba = '0;
  logic [AW-1:0] req_row = '0;
  logic [CW-1:0] req_col = '0;
  logic          act_n, cs_n, cke, row_hit, cmd_done;
  logic [AW-1:0] A;
  logic [1:0]    bg, ba;

  int n_checks = 0;
  int n_pass   = 0;

  bit            mopen [16];
  logic [AW-1:0] mrow  [16];

  ddr4_cmd_issuer #(
    .BGWIDTH(2), .BAWIDTH(2), .ADDRWIDTH(AW), .COLWIDTH(CW),
    .TRP(TRP), .TRCD(TRCD), .TBURST(TBURST)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_wr(req_wr), .req_bg(req_bg), .req_ba(req_ba), .req_row(req_row),
    .req_col(req_col), .act_n(act_n), .A(A), .bg(bg), .ba(ba), .cs_n(cs_n),
    .cke(cke), .row_hit(row_hit), .cmd_done(cmd_done)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_model();
    for (int i = 0; i < 16; i++) mopen[i] = 1'b0;
  endtask

  // Issues one request and checks every pin for each cycle until ready returns.
  // abort_at > 0 asserts reset right after checking that cycle and returns.
  task automatic do_req(input string nm, input bit wr, input logic [1:0] g, input logic [1:0] b,
                        input logic [AW-1:0] row, input logic [CW-1:0] col,
                        input bit toggle, input int abort_at);
    int idx, tp, ta, tc, trdy, w;
    logic [AW-1:0] ea;
    logic [1:0] ebg, eba;
    logic ecs, eact, ehit, edone, erdy;
    logic [25:0] got, exp;
    w = 0;
    while (req_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (req_ready !== 1'b1) begin
      n_checks++;
      $display("FAIL %s wait_ready: req_ready=%b required 1", nm, req_ready);
      return;
    end
    req_valid = 1'b1; req_wr = wr; req_bg = g; req_ba = b; req_row = row; req_col = col;
    idx = {g, b};
    tp = 0; ta = 0;
    if (mopen[idx] && mrow[idx] == row) tc = 1;
    else if (mopen[idx]) begin tp = 1; ta = 1 + TRP; tc = ta + TRCD; end
    else begin ta = 1; tc = 1 + TRCD; end
    trdy = tc + 1 + TBURST;
    mopen[idx] = 1'b1;
    mrow[idx]  = row;
    @(posedge clk);
    for (int k = 1; k <= trdy; k++) begin
      @(negedge clk);
      ecs = 1; eact = 1; ea = '0; ebg = '0; eba = '0; ehit = 0; edone = 0;
      if (k == tp) begin
        ecs = 0; ea[16:14] = 3'b010; ebg = g; eba = b;
      end else if (k == ta) begin
        ecs = 0; eact = 0; ea = row; ebg = g; eba = b;
      end else if (k == tc) begin
        ecs = 0; ea[16:14] = wr ? 3'b100 : 3'b101; ea[CW-1:0] = col;
        ebg = g; eba = b; edone = 1; ehit = (tp == 0 && ta == 0);
      end
      erdy = (k == trdy);
      exp = {ecs, eact, ea, ebg, eba, ehit, edone, erdy};
      got = {cs_n, act_n, A, bg, ba, row_hit, cmd_done, req_ready};
      n_checks++;
      if (got !== exp)
        $display("FAIL %s cycle %0d: got cs_n=%b act_n=%b A=%h bg=%0d ba=%0d hit=%b done=%b rdy=%b, required cs_n=%b act_n=%b A=%h bg=%0d ba=%0d hit=%b done=%b rdy=%b",
                 nm, k, cs_n, act_n, A, bg, ba, row_hit, cmd_done, req_ready,
                 ecs, eact, ea, ebg, eba, ehit, edone, erdy);
      else n_pass++;
      if (k == abort_at) begin
        reset = 1'b1;
        req_valid = 1'b0;
        return;
      end
      if (toggle && k < trdy - 1) begin
        req_valid = 1'($urandom_range(0, 1));
        req_wr    = 1'($urandom);
        req_bg    = 2'($urandom);
        req_ba    = 2'($urandom);
        req_row   = AW'($urandom);
        req_col   = CW'($urandom);
      end else begin
        req_valid = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    clear_model();
    reset = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if ({cs_n, act_n, cke, req_ready, row_hit, cmd_done, A} !== {4'b1100, 2'b00, 17'h0})
      $display("FAIL reset_hold: cs_n=%b act_n=%b cke=%b rdy=%b hit=%b done=%b A=%h required 1 1 0 0 0 0 0",
               cs_n, act_n, cke, req_ready, row_hit, cmd_done, A);
    else n_pass++;
    reset = 1'b0;
    req_valid = 1'b1; req_bg = 2'd0; req_ba = 2'd0; req_row = 17'h7; req_wr = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cke, req_ready, cs_n} !== 3'b111)
      $display("FAIL reset_release: cke=%b rdy=%b cs_n=%b required 1 1 1", cke, req_ready, cs_n);
    else n_pass++;
    req_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({cs_n, req_ready} !== 2'b11)
      $display("FAIL reset_no_accept: cs_n=%b rdy=%b required 1 1", cs_n, req_ready);
    else n_pass++;
  endtask

  task automatic test_closed();
    do_req("closed_read", 1'b0, 2'd1, 2'd2, 17'h00123, 10'h040, 1'b0, 0);
  endtask

  task automatic test_hit();
    do_req("hit_write", 1'b1, 2'd1, 2'd2, 17'h00123, 10'h041, 1'b0, 0);
  endtask

  task automatic test_conflict();
    do_req("conflict_read", 1'b0, 2'd1, 2'd2, 17'h00124, 10'h042, 1'b0, 0);
  endtask

  task automatic test_bank_independence();
    do_req("open_00", 1'b0, 2'd0, 2'd0, 17'h5, 10'h001, 1'b0, 0);
    do_req("closed_33", 1'b0, 2'd3, 2'd3, 17'h5, 10'h002, 1'b1, 0);
    do_req("hit_00", 1'b0, 2'd0, 2'd0, 17'h5, 10'h003, 1'b1, 0);
  endtask

  task automatic test_reset_mid();
    do_req("mid_act", 1'b0, 2'd2, 2'd1, 17'h0abcd, 10'h0ff, 1'b0, 2);
    #1;
    n_checks++;
    if ({cs_n, act_n, cke, req_ready, cmd_done} !== 5'b11000)
      $display("FAIL mid_reset_outputs: cs_n=%b act_n=%b cke=%b rdy=%b done=%b required 1 1 0 0 0",
               cs_n, act_n, cke, req_ready, cmd_done);
    else n_pass++;
    clear_model();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if ({cs_n, cmd_done} !== 2'b10)
        $display("FAIL mid_reset_quiet: cs_n=%b done=%b required 1 0", cs_n, cmd_done);
      else n_pass++;
    end
    reset = 1'b0;
    @(negedge clk);
    do_req("after_reset", 1'b0, 2'd2, 2'd1, 17'h0abcd, 10'h0ff, 1'b0, 0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      do_req("random", 1'($urandom), 2'($urandom), 2'($urandom),
             AW'($urandom_range(0, 2)), CW'($urandom), 1'($urandom), 0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++)
      do_req("b2b", 1'(i), 2'd3, 2'd0, 17'h1ffff, CW'(i), 1'b0, 0);
  endtask

  initial begin
    test_reset();
    test_closed();
    test_hit();
    test_conflict();
    test_bank_independence();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ddr4_cmd_issuer.md
# ddr4_cmd_issuer

Open-page DDR4 command generator that sits directly upstream of the `dimm` emulation model and drives its command/address pins. It accepts single read/write requests over a valid/ready handshake and tracks the open row of every bank. Each request becomes the minimal PRE/ACT/RD/WR sequence on the DDR4 pin interface, with tRP, tRCD and burst spacing enforced by internal counters.

## Interface
- BGWIDTH, 2, bank group address width
- BAWIDTH, 2, bank address width
- ADDRWIDTH, 17, A bus width; fixed at 17 (A16/A15/A14 carry ras_n/cas_n/we_n)
- COLWIDTH, 10, column width; must be ≤10 (A10 is reserved for auto-precharge)
- TRP, 3, PRE-to-ACT spacing in clk cycles; range 1..255
- TRCD, 3, ACT-to-column-command spacing in clk cycles; range 1..255
- TBURST, 4, busy cycles after a column command (BL/2); range 1..255

Ports:
- clk  in  1  command clock; shares a clock with the `dimm` model
- reset  in  1  asynchronous, active-high
- req_valid  in  1  request present
- req_ready  out  1  request accepted on a clk edge where req_valid && req_ready
- req_wr  in  1  1 = write, 0 = read
- req_bg  in  BGWIDTH  bank group
- req_ba  in  BAWIDTH  bank
- req_row  in  ADDRWIDTH  row address
- req_col  in  COLWIDTH  column address
- act_n  out  1  DDR4 activate command pin
- A  out  ADDRWIDTH  address / command pins
- bg  out  BGWIDTH  bank group pins
- ba  out  BAWIDTH  bank pins
- cs_n  out  1  chip select for a single rank
- cke  out  1  clock enable
- row_hit  out  1  one-cycle pulse with a column command when no PRE or ACT was needed
- cmd_done  out  1  one-cycle pulse in the cycle the RD/WR command is driven

## Operation
- State machine states: IDLE, PRE, WAIT_RP, ACT, WAIT_RCD, COL, WAIT_BURST.
- IDLE:
  - req_ready=1 only in IDLE; all other states hold it low.
  - On acceptance, the request fields are latched, and the bank table entry [req_bg][req_ba] is checked.
  - Open with the same row → COL.
  - Open with a different row → PRE.
  - Closed → ACT.
- PRE (one cycle): cs_n=0, act_n=1, A[16:14]=3'b010, A10=0, bg/ba=latched; clears the bank's open bit. Next state is WAIT_RP if TRP>1, else ACT.
- WAIT_RP: lasts TRP-1 cycles, then ACT.
- ACT (one cycle): cs_n=0, act_n=0, A=latched row; sets open=1 and openrow=row. Next state is WAIT_RCD if TRCD>1, else COL.
- WAIT_RCD: lasts TRCD-1 cycles, then COL.
- COL (one cycle):
  - cs_n=0, act_n=1.
  - A[16:14] = 3'b101 for a read, 3'b100 for a write.
  - A[COLWIDTH-1:0]=col; all other A bits are 0.
  - cmd_done=1; row_hit=1 only if the request was routed IDLE→COL.
  - Next state is WAIT_BURST.
- WAIT_BURST: lasts TBURST cycles, then IDLE.
- Deselect, driven in every cycle that is not PRE/ACT/COL: cs_n=1, act_n=1, A=0, bg=0, ba=0.
- Bank table: one open bit plus one ADDRWIDTH-wide row register per bank (2^BGWIDTH × 2^BAWIDTH banks). It is updated only by this block's own PRE/ACT commands; banks are fully independent.
- Request inputs are ignored outside the acceptance edge; changing them while busy has no effect.

## Timing
- Reset asserted (asynchronous):
  - state=IDLE; all open bits cleared.
  - Outputs at deselect; cke=0, req_ready=0, row_hit=0, cmd_done=0.
- First clk edge after reset deasserts: cke=1, req_ready=1.
- Cycle numbering: acceptance edge = cycle 0; the first command appears in cycle 1 (registered outputs).
- Hit: COL in cycle 1; req_ready=1 again in cycle 2+TBURST.
- Closed bank: ACT in cycle 1, COL in cycle 1+TRCD; ready in cycle 2+TRCD+TBURST.
- Conflict: PRE in cycle 1, ACT in cycle 1+TRP, COL in cycle 1+TRP+TRCD; ready in cycle 2+TRP+TRCD+TBURST.
- Exactly one non-deselect command is driven per cycle, at most.
- Wait counters are 8 bits and load on entering a wait state.
- Reset mid-sequence: outputs go to deselect immediately, the latched request is dropped and the table is cleared, so the next request to that bank issues an ACT.
- req_valid asserted in the same cycle reset deasserts: not accepted, because req_ready is still 0.

## Test plan
All scenarios use defaults (TRP=3, TRCD=3, TBURST=4).
- Reset: hold reset for 5 cycles → cs_n=1, act_n=1, cke=0, req_ready=0; after release, cke=1 and req_ready=1 on the next edge.
- Read bg=1 ba=2 row=0x00123 col=0x040, bank closed → cycle 1: act_n=0, A=0x00123, bg=1, ba=2; cycle 4: A[16:14]=101, A[9:0]=0x040, cmd_done=1, row_hit=0; req_ready=1 in cycle 9.
- Write bg=1 ba=2 row=0x00123 col=0x041 (hit) → cycle 1: A[16:14]=100, A[9:0]=0x041, row_hit=1, cmd_done=1; req_ready=1 in cycle 6.
- Read bg=1 ba=2 row=0x00124 (conflict) → PRE in cycle 1 (A[16:14]=010, A10=0); ACT with A=0x00124 in cycle 4; RD in cycle 7; req_ready=1 in cycle 12.
- Open bank 0/0 on row 5, then read bank 3/3 row 5 → bank 3/3 takes the closed path (ACT); a following read to 0/0 row 5 is a hit. Toggling req fields while busy changes no outputs.
- Assert reset in the cycle after ACT for bg=2 ba=1 (during WAIT_RCD) → no RD is driven; after reset, a read to bg=2 ba=1 with the same row issues an ACT in cycle 1, with row_hit=0.
